craft_round_constants_rev: RTL
==============================

# craft_round_constants_rev

Reverse-order round-constant sequencer for the CRAFT decryption datapath. It produces RC_{N-1} down to RC_0 using the same 4-bit `a` and 3-bit `b` LFSR pair as the forward generator. The LFSRs run backward via their inverse update. On `start`, the block first seeks forward to the last round, then presents one constant per `advance` until round 0 has been consumed.

## Interface
- `NUM_ROUNDS`, default 32: number of constants in one sequence. Legal range is 1..32.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a new sequence. Accepted only in IDLE.
- `advance` input, 1 bit: consume the current constant. Honoured only in RUN.
- `abort` input, 1 bit: synchronous return to IDLE. No `done` is produced.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `valid` output, 1 bit: high in RUN only.
- `rc` output, 8 bits: `{a,1'b0,b}` for the current round. 8'h00 when `valid`=0.
- `rc_next` output, 8 bits: constant for round−1. 8'h00 when `valid`=0 or `round`=0.
- `round` output, 5 bits: index of the current round.
- `last` output, 1 bit: `valid` && `round`==0.
- `done` output, 1 bit: one-cycle pulse after the round-0 constant is consumed.

## Operation
- **Forward step** (matches the encryption generator):
  - a' = {a2^a1, a1^a0, a3, a2}
  - b' = {b2^b1, b1^b0, b2}
- **Inverse step**, with n denoting the current value:
  - a = {n1, n0, n3^n0, n2^n3^n0}
  - b = {n0, n2^n0, n1^n2^n0}
- **States:** IDLE, SEEK, RUN.
- **IDLE:**
  - `start`=1 sets a←4'h1, b←3'h1, cnt←0.
  - Next state is SEEK if `NUM_ROUNDS`>1, otherwise RUN.
- **SEEK:**
  - Each cycle: forward step and cnt←cnt+1.
  - On the edge where cnt becomes `NUM_ROUNDS`−1, the state goes to RUN.
  - `advance` is ignored.
- **RUN:**
  - `rc` = `{a,0,b}` and `round` = cnt.
  - `rc_next` = `{inv(a),0,inv(b)}`, computed combinationally. It is 8'h00 when cnt==0.
  - `advance` with cnt>0: inverse step and cnt←cnt−1.
  - `advance` with cnt==0: state←IDLE and `done`←1 for one cycle.
  - Without `advance`, all outputs hold.
- **`start` outside IDLE** is ignored. This includes start during SEEK and RUN.
- **`abort`** has priority over `start` and `advance`.
  - From any state: state←IDLE, cnt←0, a,b←1. No `done`.
- **`start` in the `done` cycle** is accepted, because the state is already IDLE.
- **Reset values:** state=IDLE, a=4'h1, b=3'h1, cnt=0. All outputs are 0.
- **Round-constant sequence:** with `a` period 15 (1,4,9,6,5,D,F,3,8,2,C,B,A,E,7) and `b` period 7 (1,2,6,3,4,5,7), RC_i = `{a[i mod 15],0,b[i mod 7]}`.
- **`done`** is a registered output.

## Timing
- If `start` is sampled at edge t, `valid` rises after edge t+`NUM_ROUNDS`−1.
  - For N=32 that is 31 SEEK cycles.
  - For N=1, `valid` rises after edge t.
- Each `advance` sampled at a RUN edge updates `rc`/`round` after that same edge. This gives one constant per cycle at full rate.
- The `done` pulse appears in the cycle after the final `advance`. `valid`=0 in that cycle.
- `rc_next` equals the `rc` presented after the next `advance`. It has zero added latency.
- Deasserting `rst_n` mid-sequence clears outputs immediately, without waiting for a clock edge.

## Test plan
- **Seek to last round:** reset, then `start` with N=32.
  - `busy`=1 and `valid`=0 for 31 cycles.
  - Then `rc`=0x43, `rc_next`=0x16, `round`=31.
- **Full-rate run:** hold `advance`=1.
  - Sequence is 0x43, 0x16, 0x72, 0xE1, …, 0x42, 0x11.
  - At 0x11: `last`=1, `rc_next`=0x00.
  - Next cycle: `done`=1, `valid`=0, `busy`=0.
- **Cross-check against the forward generator:** capture 32 forward `rc` values from the forward generator.
  - The reverse run must match that list reversed, bit-exact.
  - Insert random `advance` gaps; `rc` must hold during each gap.
- **Ignored inputs:**
  - `advance` during SEEK: no effect, and `valid` timing is unchanged.
  - `start` during RUN at `round`=20: sequence continues at 20.
- **Abort and reset mid-operation:**
  - `abort` at `round`=10: IDLE next cycle, `done` stays 0, outputs are 0.
  - `rst_n`=0 mid-SEEK: outputs are 0 immediately.
  - A fresh `start` after either again yields 0x43 after 31 cycles.
- **Back-to-back and minimum size:**
  - `start` in the `done` cycle restarts the sequence correctly.
  - With N=1: `valid` is high one cycle after `start`, `rc`=0x11, `last`=1.

Source files
------------

// File: rtl/craft_round_constants_rev.sv
// Reverse-order CRAFT round constants: seeks forward to RC_{N-1}, then steps the LFSRs backward one round per advance.
// First constant NUM_ROUNDS-1 cycles after start; advance is a take-strobe and the outputs hold while it stays low.
module craft_round_constants_rev #(
   parameter int NUM_ROUNDS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       advance,
   input  logic       abort,
   output logic       busy,
   output logic       valid,
   output logic [7:0] rc,
   output logic [7:0] rc_next,
   output logic [4:0] round,
   output logic       last,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

   // cnt value at the start of the final seek cycle (unused when NUM_ROUNDS==1)
   localparam logic [4:0] SEEK_LAST = 5'(NUM_ROUNDS - 2);

   state_t     state;
   logic [3:0] a;
   logic [2:0] b;
   logic [4:0] cnt;

   logic [3:0] a_fwd, a_inv;
   logic [2:0] b_fwd, b_inv;

   assign a_fwd = {a[2] ^ a[1], a[1] ^ a[0], a[3], a[2]};
   assign b_fwd = {b[2] ^ b[1], b[1] ^ b[0], b[2]};
   assign a_inv = {a[1], a[0], a[3] ^ a[0], a[2] ^ a[3] ^ a[0]};
   assign b_inv = {b[0], b[2] ^ b[0], b[1] ^ b[2] ^ b[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a     <= 4'h1;
         b     <= 3'h1;
         cnt   <= 5'd0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            a     <= 4'h1;
            b     <= 3'h1;
            cnt   <= 5'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     a     <= 4'h1;
                     b     <= 3'h1;
                     cnt   <= 5'd0;
                     state <= (NUM_ROUNDS > 1) ? SEEK : RUN;
                  end
               end
               SEEK: begin
                  a   <= a_fwd;
                  b   <= b_fwd;
                  cnt <= cnt + 5'd1;
                  if (cnt == SEEK_LAST)
                     state <= RUN;
               end
               RUN: begin
                  if (advance) begin
                     if (cnt != 5'd0) begin
                        a   <= a_inv;
                        b   <= b_inv;
                        cnt <= cnt - 5'd1;
                     end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy    = (state != IDLE);
   assign valid   = (state == RUN);
   assign rc      = valid ? {a, 1'b0, b} : 8'h00;
   assign rc_next = (valid && cnt != 5'd0) ? {a_inv, 1'b0, b_inv} : 8'h00;
   assign round   = valid ? cnt : 5'd0;
   assign last    = valid && (cnt == 5'd0);

endmodule
